// File: rtl/matmul_if.sv
// Bus bundle for matmul_engine: control handshake, A/B RAM read ports and the C output stream.
interface matmul_if #(
  parameter int N         = 2,
  parameter int dataWidth = 4,
  parameter int accWidth  = 2*dataWidth + $clog2(N)
);
  localparam int AW = $clog2(N*N);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        a_rdaddr;
  logic [dataWidth-1:0] a_rddata;
  logic [AW-1:0]        b_rdaddr;
  logic [dataWidth-1:0] b_rddata;
  logic                 c_valid;
  logic                 c_ready;
  logic [accWidth-1:0]  c_data;
  logic [AW-1:0]        c_index;

  modport master (
    input  start, a_rddata, b_rddata, c_ready,
    output busy, done, a_rdaddr, b_rdaddr, c_valid, c_data, c_index
  );

  modport slave (
    output start, a_rddata, b_rddata, c_ready,
    input  busy, done, a_rdaddr, b_rdaddr, c_valid, c_data, c_index
  );
endinterface

// File: rtl/matmul_engine.sv
// Streams C = A x B one element at a time: N reads of row i of A and column j of B,
// an unsigned multiply-accumulate fed by 1-cycle RAM reads, then a valid/ready handoff.
module matmul_engine #(
  parameter int N         = 2,
  parameter int dataWidth = 4,
  parameter int accWidth  = 2*dataWidth + $clog2(N)
) (
  input  logic      clk,
  input  logic      rst,
  matmul_if.master  bus
);
  localparam int AW = $clog2(N*N);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [2:0] {
    IDLE_ST = 3'd0,
    READ_ST = 3'd1,
    WAIT_ST = 3'd2,
    OUT_ST  = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  state_t               state_r, state_next_s;
  logic [CW-1:0]        i_r, j_r, k_r;
  logic [CW-1:0]        i_next_s, j_next_s, k_next_s;
  logic [accWidth-1:0]  acc_r, acc_next_s, prod_s;
  logic                 rd_vld_r;
  logic                 busy_r, done_r, c_valid_r;
  logic [AW-1:0]        a_rdaddr_r, b_rdaddr_r, c_index_r;

  assign prod_s = accWidth'(bus.a_rddata) * accWidth'(bus.b_rddata);

  // Next-state, counter and accumulator update logic
  always_comb begin
    state_next_s = state_r;
    i_next_s     = i_r;
    j_next_s     = j_r;
    k_next_s     = k_r;
    if (rd_vld_r) begin
      acc_next_s = acc_r + prod_s;
    end else begin
      acc_next_s = acc_r;
    end
    case (state_r)
      IDLE_ST: begin
        if (bus.start) begin
          state_next_s = READ_ST;
          i_next_s     = CW'(0);
          j_next_s     = CW'(0);
          k_next_s     = CW'(0);
          acc_next_s   = accWidth'(0);
        end else begin
          state_next_s = IDLE_ST;
        end
      end
      READ_ST: begin
        if (k_r == LAST) begin
          state_next_s = WAIT_ST;
          k_next_s     = CW'(0);
        end else begin
          k_next_s     = k_r + CW'(1);
        end
      end
      WAIT_ST: begin
        state_next_s = OUT_ST;
      end
      OUT_ST: begin
        if (bus.c_ready) begin
          acc_next_s = accWidth'(0);
          if (j_r == LAST) begin
            j_next_s = CW'(0);
            if (i_r == LAST) begin
              i_next_s     = CW'(0);
              state_next_s = DONE_ST;
            end else begin
              i_next_s     = i_r + CW'(1);
              state_next_s = READ_ST;
            end
          end else begin
            j_next_s     = j_r + CW'(1);
            state_next_s = READ_ST;
          end
        end else begin
          state_next_s = OUT_ST;
        end
      end
      DONE_ST: begin
        state_next_s = IDLE_ST;
      end
      default: begin
        state_next_s = IDLE_ST;
      end
    endcase
  end

  // State, datapath and output registers; outputs are precomputed from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE_ST;
      i_r        <= CW'(0);
      j_r        <= CW'(0);
      k_r        <= CW'(0);
      acc_r      <= accWidth'(0);
      rd_vld_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      c_valid_r  <= 1'b0;
      a_rdaddr_r <= AW'(0);
      b_rdaddr_r <= AW'(0);
      c_index_r  <= AW'(0);
    end else begin
      state_r    <= state_next_s;
      i_r        <= i_next_s;
      j_r        <= j_next_s;
      k_r        <= k_next_s;
      acc_r      <= acc_next_s;
      rd_vld_r   <= (state_r == READ_ST);
      busy_r     <= (state_next_s == READ_ST) || (state_next_s == WAIT_ST) ||
                    (state_next_s == OUT_ST);
      done_r     <= (state_next_s == DONE_ST);
      c_valid_r  <= (state_next_s == OUT_ST);
      a_rdaddr_r <= AW'(i_next_s) * AW'(N) + AW'(k_next_s);
      b_rdaddr_r <= AW'(k_next_s) * AW'(N) + AW'(j_next_s);
      c_index_r  <= AW'(i_next_s) * AW'(N) + AW'(j_next_s);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.c_valid  = c_valid_r;
  assign bus.c_data   = acc_r;
  assign bus.c_index  = c_index_r;
  assign bus.a_rdaddr = a_rdaddr_r;
  assign bus.b_rdaddr = b_rdaddr_r;
endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine at N=2 and N=3, with behavioural RAMs and a matrix-product model.
module tb_matmul_engine;
  typedef struct {
    int idx;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   out2 = 0, done2 = 0, out3 = 0, done3 = 0;
  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  logic [3:0] a2[4];
  logic [3:0] b2[4];
  logic [3:0] a3[9];
  logic [3:0] b3[9];

  always #5 clk = ~clk;

  matmul_if #(.N(2), .dataWidth(4)) bus2 ();
  matmul_if #(.N(3), .dataWidth(4)) bus3 ();

  matmul_engine #(.N(2), .dataWidth(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));
  matmul_engine #(.N(3), .dataWidth(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

  // Registered-read RAM models
  always @(posedge clk) begin
    bus2.a_rddata <= a2[bus2.a_rdaddr];
    bus2.b_rddata <= b2[bus2.b_rdaddr];
    bus3.a_rddata <= a3[bus3.a_rdaddr];
    bus3.b_rddata <= b3[bus3.b_rdaddr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard on every accepted C transfer, count done pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.c_valid && bus2.c_ready) begin
        out2++;
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n2_unexpected_output index=%0d data=%0d required=no output",
                   bus2.c_index, bus2.c_data);
        end else begin
          e2 = q2.pop_front();
          check("n2_c_index", bus2.c_index, e2.idx);
          check("n2_c_data", bus2.c_data, e2.data);
        end
      end
      if (bus2.done) done2++;
      if (bus3.c_valid && bus3.c_ready) begin
        out3++;
        if (q3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n3_unexpected_output index=%0d data=%0d required=no output",
                   bus3.c_index, bus3.c_data);
        end else begin
          e3 = q3.pop_front();
          check("n3_c_index", bus3.c_index, e3.idx);
          check("n3_c_data", bus3.c_data, e3.data);
        end
      end
      if (bus3.done) done3++;
    end
  end

  task automatic push_exp2();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int s = 0;
        for (int m = 0; m < 2; m++) s += int'(a2[r*2+m]) * int'(b2[m*2+c]);
        q2.push_back('{r*2+c, s});
      end
  endtask

  task automatic push_exp3();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int s = 0;
        for (int m = 0; m < 3; m++) s += int'(a3[r*3+m]) * int'(b3[m*3+c]);
        q3.push_back('{r*3+c, s});
      end
  endtask

  task automatic load_basic();
    for (int n = 0; n < 4; n++) begin
      a2[n] = 4'(n + 1);
      b2[n] = 4'(n + 5);
    end
  endtask

  task automatic start_pulse2();
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    check("n2_busy_after_start", bus2.busy, 1);
  endtask

  // Edges are counted from the start-accepting edge; poke re-asserts start mid-run
  task automatic run2(input bit rand_rdy, input bit poke, output int first_v, output int done_at);
    first_v = -1;
    done_at = -1;
    start_pulse2();
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (first_v < 0 && bus2.c_valid) first_v = n;
      if (bus2.done) begin
        done_at = n;
        break;
      end
      if (rand_rdy) bus2.c_ready = 1'($urandom_range(0, 1));
      if (poke) bus2.start = (n == 6 || n == 7);
    end
    bus2.c_ready = 1'b1;
    bus2.start = 1'b0;
    check("n2_run_finished", done_at > 0, 1);
  endtask

  task automatic run3(input bit rand_rdy, output int first_v, output int done_at);
    first_v = -1;
    done_at = -1;
    @(posedge clk); #1 bus3.start = 1'b1;
    @(posedge clk); #1 bus3.start = 1'b0;
    check("n3_busy_after_start", bus3.busy, 1);
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (first_v < 0 && bus3.c_valid) first_v = n;
      if (bus3.done) begin
        done_at = n;
        break;
      end
      if (rand_rdy) bus3.c_ready = 1'($urandom_range(0, 1));
    end
    bus3.c_ready = 1'b1;
    check("n3_run_finished", done_at > 0, 1);
  endtask

  task automatic tail2(input int o0, input int d0);
    @(negedge clk); #1;
    check("n2_output_count", out2 - o0, 4);
    check("n2_done_count", done2 - d0, 1);
    check("n2_queue_empty", q2.size(), 0);
  endtask

  task automatic wait_valid2();
    for (int n = 0; n < 50; n++) begin
      if (bus2.c_valid) break;
      @(posedge clk); #1;
    end
    check("n2_valid_seen", bus2.c_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int fv, da, o0, d0;
    bus2.start = 1'b0; bus2.c_ready = 1'b0;
    bus3.start = 1'b0; bus3.c_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin a2[n] = 4'd0; b2[n] = 4'd0; end
    for (int n = 0; n < 9; n++) begin a3[n] = 4'd0; b3[n] = 4'd0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_valid", bus2.c_valid, 0);
    check("rst_busy", bus2.busy, 0);
    check("rst_done", bus2.done, 0);
    check("rst_c_data", bus2.c_data, 0);
    check("rst_c_index", bus2.c_index, 0);
    check("rst_a_rdaddr", bus2.a_rdaddr, 0);
    check("rst_b_rdaddr", bus2.b_rdaddr, 0);
    check("rst_n3_c_valid", bus3.c_valid, 0);
    rst = 1'b0;
    bus2.c_ready = 1'b1;
    bus3.c_ready = 1'b1;

    // Basic product with latency
    load_basic(); push_exp2(); o0 = out2; d0 = done2;
    run2(1'b0, 1'b0, fv, da);
    check("n2_first_valid_edges", fv, 3);
    check("n2_done_edges", da, 16);
    tail2(o0, d0);

    // Maximum operands
    for (int n = 0; n < 4; n++) begin a2[n] = 4'd15; b2[n] = 4'd15; end
    push_exp2(); o0 = out2; d0 = done2;
    run2(1'b0, 1'b0, fv, da);
    tail2(o0, d0);

    // Random operands with random backpressure, then one with fixed timing
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        a2[n] = 4'($urandom_range(0, 15));
        b2[n] = 4'($urandom_range(0, 15));
      end
      push_exp2(); o0 = out2; d0 = done2;
      run2(r != 3, 1'b0, fv, da);
      if (r == 3) check("n2_rand_done_edges", da, 16);
      tail2(o0, d0);
    end

    // Backpressure on element 1
    load_basic(); push_exp2(); o0 = out2; d0 = done2;
    start_pulse2();
    wait_valid2();
    @(posedge clk); #1 bus2.c_ready = 1'b0;
    wait_valid2();
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("bp_c_valid", bus2.c_valid, 1);
      check("bp_c_data", bus2.c_data, 22);
      check("bp_c_index", bus2.c_index, 1);
      check("bp_a_rdaddr", bus2.a_rdaddr, 0);
      check("bp_b_rdaddr", bus2.b_rdaddr, 1);
    end
    bus2.c_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (bus2.done) break;
    end
    check("bp_done_seen", bus2.done, 1);
    tail2(o0, d0);

    // Start while busy and during DONE is ignored
    push_exp2(); o0 = out2; d0 = done2;
    run2(1'b0, 1'b1, fv, da);
    check("restart_done_edges", da, 16);
    bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("restart_busy_low", bus2.busy, 0);
      @(posedge clk); #1;
    end
    check("restart_c_valid_low", bus2.c_valid, 0);
    tail2(o0, d0);

    // Reset during element 2's READ aborts without done
    push_exp2(); o0 = out2; d0 = done2;
    start_pulse2();
    repeat (8) @(posedge clk);
    #1;
    check("abort_outputs_before_rst", out2 - o0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_c_valid", bus2.c_valid, 0);
    check("abort_busy", bus2.busy, 0);
    check("abort_done", bus2.done, 0);
    rst = 1'b0;
    q2.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done2 - d0, 0);
    push_exp2(); o0 = out2; d0 = done2;
    run2(1'b0, 1'b0, fv, da);
    check("after_abort_done_edges", da, 16);
    tail2(o0, d0);

    // Identity A at N=3
    for (int n = 0; n < 9; n++) begin
      a3[n] = (n % 4 == 0) ? 4'd1 : 4'd0;
      b3[n] = 4'(n + 1);
    end
    push_exp3(); o0 = out3; d0 = done3;
    run3(1'b0, fv, da);
    check("n3_first_valid_edges", fv, 4);
    check("n3_done_edges", da, 45);
    @(negedge clk); #1;
    check("n3_output_count", out3 - o0, 9);
    check("n3_done_count", done3 - d0, 1);

    // Random N=3 with random backpressure
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 9; n++) begin
        a3[n] = 4'($urandom_range(0, 15));
        b3[n] = 4'($urandom_range(0, 15));
      end
      push_exp3(); o0 = out3; d0 = done3;
      run3(1'b1, fv, da);
      @(negedge clk); #1;
      check("n3_rand_output_count", out3 - o0, 9);
      check("n3_rand_done_count", done3 - d0, 1);
    end
    check("n3_queue_empty", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
